// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and execute-stage state type
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_ex_state_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - operation/result handshake bundle of the ALU execute stage
interface alu_exec_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alucontrol;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    // Upstream decoder plus downstream consumer side
    modport master (
        output in_valid, alucontrol, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // Execute stage side
    modport slave (
        input  in_valid, alucontrol, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - one-bit-per-cycle logical shifter with down-counter and done flag
module alu_serial_shifter #(
    parameter  int XLEN = 64,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_dir_right,
    input  logic [XLEN-1:0] i_data,
    input  logic [SHW-1:0]  i_amt,
    output logic [XLEN-1:0] o_data,
    output logic            o_done
);
    logic [XLEN-1:0] r_data;
    logic [SHW-1:0]  r_count;
    logic            r_dir_right;

    // Load operand and amount, then shift one zero-filled bit per cycle until the count runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_count     <= '0;
            r_dir_right <= 1'b0;
        end else if (i_load) begin
            r_data      <= i_data;
            r_count     <= i_amt;
            r_dir_right <= i_dir_right;
        end else if (r_count != '0) begin
            r_data  <= r_dir_right ? {1'b0, r_data[XLEN-1:1]} : {r_data[XLEN-2:0], 1'b0};
            r_count <= r_count - SHW'(1);
        end
    end

    assign o_data = r_data;
    assign o_done = (r_count == '0);
endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - handshaked ALU execute stage; ALU_SHIFT_EN adds the iterative SLL/SRL path
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic              clk,
    input logic              rst_n,
    alu_exec_stage_if.slave  bus
);
    logic [XLEN-1:0] w_alu_data;
    logic            w_alu_illegal;
    logic [XLEN-1:0] w_out_data;
    logic            w_out_illegal;
    logic            w_load_out;
    logic            w_in_ready;
    logic            w_slot_free;

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;
    logic            r_out_valid;

`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(XLEN);

    alu_ex_state_t   r_state;
    alu_ex_state_t   w_state_nxt;
    logic            w_is_shift;
    logic            w_shift_right;
    logic            w_shift_load;
    logic            w_sh_done;
    logic [XLEN-1:0] w_sh_data;
`endif

    // Result slot can take a new value if empty or being drained this cycle
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Decode the control code into a single-cycle result; unsupported codes yield zero and flag illegal
    always_comb begin
        w_alu_data    = '0;
        w_alu_illegal = 1'b0;
`ifdef ALU_SHIFT_EN
        w_is_shift    = 1'b0;
        w_shift_right = 1'b0;
`endif
        case (bus.alucontrol)
            ALU_AND: w_alu_data = bus.a & bus.b;
            ALU_OR:  w_alu_data = bus.a | bus.b;
            ALU_ADD: w_alu_data = bus.a + bus.b;
            ALU_SUB: w_alu_data = bus.a - bus.b;
            ALU_SLL: begin
`ifdef ALU_SHIFT_EN
                w_is_shift    = 1'b1;
`else
                w_alu_illegal = 1'b1;
`endif
            end
            ALU_SRL: begin
`ifdef ALU_SHIFT_EN
                w_is_shift    = 1'b1;
                w_shift_right = 1'b1;
`else
                w_alu_illegal = 1'b1;
`endif
            end
            default: w_alu_illegal = 1'b1;
        endcase
    end

`ifdef ALU_SHIFT_EN
    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control: shifts park in SHIFT until the count expires and the slot frees up
    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        w_load_out    = 1'b0;
        w_shift_load  = 1'b0;
        w_out_data    = w_alu_data;
        w_out_illegal = w_alu_illegal;
        case (r_state)
            IDLE: begin
                w_in_ready = w_slot_free;
                if (bus.in_valid && w_slot_free) begin
                    if (w_is_shift) begin
                        w_shift_load = 1'b1;
                        w_state_nxt  = SHIFT;
                    end else begin
                        w_load_out = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (w_sh_done && w_slot_free) begin
                    w_load_out    = 1'b1;
                    w_out_data    = w_sh_data;
                    w_out_illegal = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    alu_serial_shifter #(
        .XLEN (XLEN)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_shift_load),
        .i_dir_right (w_shift_right),
        .i_data      (bus.a),
        .i_amt       (bus.b[SHW-1:0]),
        .o_data      (w_sh_data),
        .o_done      (w_sh_done)
    );
`else
    // Without the shifter every op completes in one cycle, so the stage never leaves IDLE
    always_comb begin
        w_in_ready    = w_slot_free;
        w_load_out    = bus.in_valid && w_slot_free;
        w_out_data    = w_alu_data;
        w_out_illegal = w_alu_illegal;
    end
`endif

    // Output register: loads on a completed op, otherwise holds; valid drops when drained without refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load_out) begin
            r_result    <= w_out_data;
            r_zero      <= (w_out_data == '0);
            r_illegal   <= w_out_illegal;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage with random and directed ops
module tb_alu_exec_stage;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_exec_stage_if #(.XLEN(XLEN)) bus ();

    alu_exec_stage #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] res;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   errors   = 0;
    int   checks   = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: result straight from the operation definitions; lat = extra cycles a shift spends
    function automatic void ref_op(input logic [3:0] code, input logic [63:0] x, input logic [63:0] y,
                                   output logic [63:0] r, output logic ill, output int lat);
        r   = '0;
        ill = 1'b0;
        lat = 0;
        case (code)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
`ifdef ALU_SHIFT_EN
            4'b0011: begin r = x << y[5:0]; lat = int'(y[5:0]) + 1; end
            4'b0100: begin r = x >> y[5:0]; lat = int'(y[5:0]) + 1; end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Present an op until accepted, then record its expected result and due cycle
    task automatic send(input logic [3:0] c, input logic [63:0] x, input logic [63:0] y, input bit rand_rdy);
        logic [63:0] r;
        logic        ill;
        int          lat;
        bit          acc;
        int          e;
        int          tries;
        bus.alucontrol = c;
        bus.a          = x;
        bus.b          = y;
        bus.in_valid   = 1'b1;
        acc   = 1'b0;
        tries = 0;
        e     = 0;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            e   = edge_cnt;
            @(posedge clk);
            #1;
            tries++;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc) begin
            ref_op(c, x, y, r, ill, lat);
            sbq.push_back('{res: r, ill: ill, due: e + 1 + lat});
        end else begin
            errors++;
            $display("FAIL accept_timeout: got in_ready stuck expected accept within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: valid timing, in_ready, and result content whenever a result is due
    always @(negedge clk) begin
        bit          ev;
        logic        erdy;
        logic [63:0] er;
        ev = (sbq.size() > 0) && (edge_cnt >= sbq[0].due);
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ev});
        if (sbq.size() == 0)
            erdy = 1'b1;
        else
            erdy = ev ? bus.out_ready : 1'b0;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, erdy});
        if (ev && bus.out_valid) begin
            er = sbq[0].res;
            chk("result", bus.result, er);
            chk("zero", {63'd0, bus.zero}, {63'd0, (er == 64'd0)});
            chk("illegal", {63'd0, bus.illegal}, {63'd0, sbq[0].ill});
            if (bus.out_ready) void'(sbq.pop_front());
        end
    end

    initial begin
        logic [3:0]  codes[6];
        logic [3:0]  c;
        logic [63:0] x;
        logic [63:0] y;
        int          drain;
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010;
        codes[3] = 4'b0110; codes[4] = 4'b0011; codes[5] = 4'b0100;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.alucontrol = 4'b0000;
        bus.a          = '0;
        bus.b          = '0;
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_zero", {63'd0, bus.zero}, 64'd0);
        chk("rst_illegal", {63'd0, bus.illegal}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // ADD 5+7 visible right after the accept edge
        bus.out_ready = 1'b1;
        send(4'b0010, 64'd5, 64'd7, 1'b0);
        chk("add_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("add_result", bus.result, 64'd12);

        // Back-to-back SUB then AND
        send(4'b0110, 64'd9, 64'd9, 1'b0);
        send(4'b0000, 64'hF0, 64'h0F, 1'b0);
        idle(2);

        // Stall: OR held for 3 cycles, then drain and fill with an ADD
        bus.out_ready = 1'b0;
        send(4'b0001, 64'h1, 64'h2, 1'b0);
        idle(3);
        bus.out_ready = 1'b1;
        send(4'b0010, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("fill_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("fill_result", bus.result, 64'd99);
        idle(2);

        // Unsupported code
        send(4'b1111, 64'h1234, 64'h5678, 1'b0);
        chk("ill_flag", {63'd0, bus.illegal}, 64'd1);
        chk("ill_result", bus.result, 64'd0);
        chk("ill_zero", {63'd0, bus.zero}, 64'd1);
        idle(2);

        // Shift codes: iterative with the shifter, illegal without
        send(4'b0011, 64'd1, 64'd63, 1'b0);
        idle(70);
        send(4'b0100, 64'hDEAD_BEEF_0123_4567, 64'd64, 1'b0);
        idle(4);

        // Reset during an in-flight op (shift by 40, reset 20 cycles in)
        send(4'b0011, 64'hFFFF, 64'd40, 1'b0);
        idle(20);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_result", bus.result, 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(60);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 6) == 6) c = 4'($urandom_range(0, 15));
            else                           c = codes[$urandom_range(0, 5)];
            x = {$urandom, $urandom};
            y = ($urandom_range(0, 7) == 0) ? x : {$urandom, $urandom};
            send(c, x, y, 1'b1);
        end

        bus.out_ready = 1'b1;
        drain = 0;
        while (sbq.size() > 0 && drain < 200) begin
            idle(1);
            drain++;
        end
        checks++;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding expected 0", sbq.size());
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Handshaked execute stage directly downstream of the ALU control decoder. It consumes the 4-bit `alucontrol` code and two operands, then produces a registered result plus a zero flag for the branch/memory stage. Logic ops, add and sub complete in one cycle. With the shift feature compiled in, SLL/SRL run as an iterative one-bit-per-cycle shifter.

## Interface
- `XLEN`, 64: operand/result width.
- `SHW`, `$clog2(XLEN)`: shift-amount width, derived and not overridable.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: stage accepts an operation this cycle.
- `alucontrol` input 4: operation code from the ALU control decoder.
- `a`, `b` input XLEN each: operands; `b[SHW-1:0]` is the shift amount.
- `out_valid` output 1: result register holds a valid result.
- `out_ready` input 1: consumer takes the result.
- `result` output XLEN: registered result.
- `zero` output 1: `result == 0`, registered alongside `result`.
- `illegal` output 1: unsupported code was accepted; `result` = 0.

## Operation
- Codes:
  - `0000` AND, `0001` OR, `0010` ADD (ld/sd address), `0110` SUB (beq compare).
  - `0011` SLL, `0100` SRL: only with the macro.
  - Every other code, including X, is illegal.
- Arithmetic is modulo 2^XLEN. Carry and overflow are discarded. Shifts are logical and zero-fill.
- Accept happens when `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready = !out_valid || out_ready`.
    - Accept of a single-cycle or illegal op: load the output register and stay in IDLE.
    - Accept of a shift: load the working register with `a` and the counter with `b[SHW-1:0]`, then go to SHIFT.
  - SHIFT: `in_ready = 0`.
    - While count > 0: shift the working register one bit and decrement count each cycle.
    - When count == 0 and `(!out_valid || out_ready)`: write the output register and return to IDLE.
    - When count == 0 and the slot is still occupied: hold.
- Output register: `result`, `zero` and `illegal` stay stable while `out_valid && !out_ready`.
- `out_valid` clears on `out_ready` unless a new result is written in the same cycle.
- Reset values, including reset mid-operation: `out_valid = 0`, `result = 0`, `zero = 0`, `illegal = 0`, state IDLE, counter 0.
  - `in_ready` reads 1 during and after reset.
  - An in-flight shift is dropped and no partial result appears.

## Timing
- Single-cycle ops: accept at edge k, `out_valid` at k+1. Throughput is one op per cycle when `out_ready` is held high.
- Shift by n: accept at edge k, `out_valid` at k+n+1 (shift by 0 takes 1 cycle, shift by XLEN-1 takes XLEN cycles), plus any stall cycles waiting on `out_ready`.
- The stage issues no new accept until the cycle after SHIFT exits.
- Simultaneous drain and fill: `out_ready` and accept in the same cycle drops the old result and loads the new one, so `out_valid` stays 1.
- There is no combinational path from `a`/`b`/`alucontrol` to any output. `in_ready` depends on `out_ready` combinationally.

## Configuration
- `ALU_SHIFT_EN` defined:
  - SHIFT state, working register, counter and the codes `0011`/`0100` are present.
- `ALU_SHIFT_EN` undefined:
  - `0011`/`0100` are illegal and complete in one cycle with `illegal = 1` and `result = 0`.
  - The FSM reduces to IDLE only.
  - No shifter logic is synthesised.

## Structure
- Shared package `alu_pkg`:
  - localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLL`, `ALU_SRL`;
  - state enum `alu_ex_state_t` {IDLE, SHIFT}.
- The decoder uses the same package constants.
- One sub-module: `alu_serial_shifter`, covering the working register, counter, direction and done flag. It is instantiated only under `ALU_SHIFT_EN`.

## Test plan
- ADD `a=5`, `b=7` accepted at edge k -> `result=12`, `zero=0` and `out_valid=1` at k+1.
- Back-to-back SUB `9-9` then AND `F0&0F`, `out_ready=1` -> results `0/zero=1`, then `0/zero=1`, on consecutive cycles, and `in_ready` stays 1.
- `out_ready=0` for 3 cycles after an OR `0x1|0x2` -> `result=3` held stable, `in_ready=0`. Releasing `out_ready` with a new ADD presented gives drain and fill in the same cycle.
- With `ALU_SHIFT_EN`: SLL `a=1`, `b=63` -> `result=0x8000000000000000` exactly 64 cycles after accept, `in_ready=0` throughout. SRL by 0 -> `result=a` after 1 cycle.
- Without `ALU_SHIFT_EN`, or with code `1111` -> `illegal=1`, `result=0`, `zero=1`, 1-cycle latency.
- `rst_n` asserted mid-SHIFT (count=20) -> `out_valid=0`, `result=0` immediately, and no output appears after release.
